game_manager: RTL and testbench

Top-level game sequencer between the keypad level selector and the note datapath (spawner/judge). It latches the selected difficulty and derives spawn speed and note budget. It paces note spawns with a fractional tick accumulator, tallies hit/miss results from the judge, and sequences IDLE → PLAY → DRAIN → DONE. It returns to IDLE on a restart request.

---
 rtl/game_manager.sv | 207 ++++++++++++++++++++
 tb/tb_game_manager.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_manager.sv
// game_manager: game sequencer between the keypad level selector and the
// note spawner/judge. It latches the difficulty, paces spawns with a
// fractional tick accumulator, tallies judge results and steps through
// IDLE -> PLAY -> DRAIN -> DONE until a restart returns it to IDLE.
module game_manager #(
    parameter int TICK_DIV = 1000,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         level,
    input  logic               level_valid,
    input  logic               restart,
    input  logic               hit,
    input  logic               miss,
    output logic               spawn,
    output logic [2:0]         speed,
    output logic [4:0]         note_total,
    output logic [4:0]         notes_left,
    output logic [SCORE_W-1:0] score,
    output logic               playing,
    output logic               game_over,
    output logic               level_err,
    output logic [1:0]         state
);

    // The accumulator never exceeds TICK_DIV-1+4, so three spare bits are ample.
    localparam int ACC_W = $clog2(TICK_DIV) + 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               armed_q, armed_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [4:0]         spawned_q, spawned_d;
    logic [4:0]         resolved_q, resolved_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         speed_q, speed_d;
    logic [4:0]         note_total_q, note_total_d;
    logic [4:0]         notes_left_q, notes_left_d;
    logic               spawn_q, spawn_d;
    logic               level_err_q, level_err_d;

    logic [ACC_W-1:0]   acc_sum;
    logic               tick_due;
    logic               level_onehot;
    logic [5:0]         res_sum;
    logic [SCORE_W-1:0] score_cnt;
    logic [4:0]         resolved_cnt;

    // Shared arithmetic: next accumulator value, and saturating result counters.
    always_comb begin
        acc_sum      = acc_q + {{(ACC_W-3){1'b0}}, speed_q};
        tick_due     = (acc_sum >= ACC_W'(TICK_DIV));
        level_onehot = (level == 3'b001) || (level == 3'b010) || (level == 3'b100);

        // hit and miss together resolve two notes but score only one.
        res_sum = {1'b0, resolved_q} + {5'd0, hit} + {5'd0, miss};
        if (res_sum >= {1'b0, note_total_q}) begin
            resolved_cnt = note_total_q;
        end else begin
            resolved_cnt = res_sum[4:0];
        end

        if (hit && (score_q != {SCORE_W{1'b1}})) begin
            score_cnt = score_q + 1'b1;
        end else begin
            score_cnt = score_q;
        end
    end

    // Next-state logic for the sequencer and every registered output.
    always_comb begin
        // NOTE: every _d starts from a default so no path leaves it unassigned,
        // which keeps this block purely combinational (no inferred latches).
        state_d      = state_q;
        armed_d      = armed_q;
        acc_d        = acc_q;
        spawned_d    = spawned_q;
        resolved_d   = resolved_q;
        score_d      = score_q;
        speed_d      = speed_q;
        note_total_d = note_total_q;
        notes_left_d = notes_left_q;
        spawn_d      = 1'b0;
        level_err_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!level_valid) begin
                    // Selector released: a fresh selection may now start a game.
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    if (level_onehot) begin
                        // The one-hot code doubles as the 1/2/4 speed multiplier.
                        speed_d = level;
                        unique case (level)
                            3'b001:  note_total_d = 5'd8;
                            3'b010:  note_total_d = 5'd12;
                            default: note_total_d = 5'd16;
                        endcase
                        notes_left_d = note_total_d;
                        acc_d        = '0;
                        spawned_d    = '0;
                        resolved_d   = '0;
                        score_d      = '0;
                        state_d      = S_PLAY;
                    end else begin
                        level_err_d = 1'b1;
                    end
                end
            end

            S_PLAY: begin
                resolved_d = resolved_cnt;
                score_d    = score_cnt;
                if (tick_due) begin
                    acc_d        = acc_sum - ACC_W'(TICK_DIV);
                    spawn_d      = 1'b1;
                    spawned_d    = spawned_q + 5'd1;
                    notes_left_d = notes_left_q - 5'd1;
                    // The edge registering the last note also leaves PLAY.
                    if ((spawned_q + 5'd1) == note_total_q) begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    acc_d = acc_sum;
                end
            end

            S_DRAIN: begin
                // Results arriving in the final DRAIN cycle still count.
                resolved_d = resolved_cnt;
                score_d    = score_cnt;
                if (resolved_q >= note_total_q) begin
                    state_d = S_DONE;
                end
            end

            default: begin
                // DONE: hold the final score and level until restart.
            end
        endcase

        // Restart overrides the state logic, including a spawn due this edge.
        if (restart) begin
            state_d      = S_IDLE;
            armed_d      = 1'b0;
            acc_d        = '0;
            spawned_d    = '0;
            resolved_d   = '0;
            score_d      = '0;
            speed_d      = '0;
            note_total_d = '0;
            notes_left_d = '0;
            spawn_d      = 1'b0;
            level_err_d  = 1'b0;
        end
    end

    // State registers with synchronous reset; armed comes up set.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking assignments so
        // every flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= S_IDLE;
            armed_q      <= 1'b1;
            acc_q        <= '0;
            spawned_q    <= '0;
            resolved_q   <= '0;
            score_q      <= '0;
            speed_q      <= '0;
            note_total_q <= '0;
            notes_left_q <= '0;
            spawn_q      <= 1'b0;
            level_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            acc_q        <= acc_d;
            spawned_q    <= spawned_d;
            resolved_q   <= resolved_d;
            score_q      <= score_d;
            speed_q      <= speed_d;
            note_total_q <= note_total_d;
            notes_left_q <= notes_left_d;
            spawn_q      <= spawn_d;
            level_err_q  <= level_err_d;
        end
    end

    assign spawn      = spawn_q;
    assign speed      = speed_q;
    assign note_total = note_total_q;
    assign notes_left = notes_left_q;
    assign score      = score_q;
    assign level_err  = level_err_q;
    assign state      = state_q;
    assign playing    = (state_q == S_PLAY) || (state_q == S_DRAIN);
    assign game_over  = (state_q == S_DONE);

endmodule

// File: tb/tb_game_manager.sv
// tb_game_manager: directed stimulus with a scoreboard. Expected spawn and
// level_err events are queued as stimulus is issued; a negedge monitor pops
// and compares them whenever the DUT pulses those outputs.
module tb_game_manager;

    localparam int TICK_DIV = 8;
    localparam int SCORE_W  = 8;

    logic               clk;
    logic               rst;
    logic [2:0]         level;
    logic               level_valid;
    logic               restart;
    logic               hit;
    logic               miss;
    logic               spawn;
    logic [2:0]         speed;
    logic [4:0]         note_total;
    logic [4:0]         notes_left;
    logic [SCORE_W-1:0] score;
    logic               playing;
    logic               game_over;
    logic               level_err;
    logic [1:0]         state;

    game_manager #(.TICK_DIV(TICK_DIV), .SCORE_W(SCORE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .level      (level),
        .level_valid(level_valid),
        .restart    (restart),
        .hit        (hit),
        .miss       (miss),
        .spawn      (spawn),
        .speed      (speed),
        .note_total (note_total),
        .notes_left (notes_left),
        .score      (score),
        .playing    (playing),
        .game_over  (game_over),
        .level_err  (level_err),
        .state      (state)
    );

    typedef struct {
        int         cyc;
        logic [4:0] left;
        logic [1:0] st;
    } spawn_exp_t;

    spawn_exp_t spawn_q[$];
    int         err_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         e0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after edge N settles, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue n spawns spaced 'gap' edges after accept edge 'start' of a game with 'total' notes.
    task automatic push_spawns(input int start, input int n, input int gap, input int total);
        spawn_exp_t e;
        for (int k = 1; k <= n; k++) begin
            e.cyc  = start + gap * k;
            e.left = 5'(total - k);
            e.st   = (k == total) ? 2'd2 : 2'd1;
            spawn_q.push_back(e);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_speed"}, speed, 0);
        check({tag, "_note_total"}, note_total, 0);
        check({tag, "_notes_left"}, notes_left, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_playing"}, playing, 0);
        check({tag, "_game_over"}, game_over, 0);
        check({tag, "_spawn"}, spawn, 0);
        check({tag, "_level_err"}, level_err, 0);
    endtask

    // Monitor: compare every spawn / level_err pulse against the scoreboard.
    always @(negedge clk) begin
        if (spawn) begin
            if (spawn_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_spawn: got spawn at cycle %0d, expected none", cyc);
            end else begin
                spawn_exp_t e;
                e = spawn_q.pop_front();
                check("spawn_cycle", cyc, e.cyc);
                check("spawn_notes_left", notes_left, e.left);
                check("spawn_state", state, e.st);
            end
        end
        if (level_err) begin
            if (err_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_level_err: got pulse at cycle %0d, expected none", cyc);
            end else begin
                check("level_err_cycle", cyc, err_q.pop_front());
            end
        end
    end

    // Watchdog: stimulus is fixed-length, this only guards against a stuck clock.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    logic [1:0] drain_vec [11];
    logic [2:0] bad_levels [2];

    initial begin
        drain_vec  = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
        bad_levels = '{3'b011, 3'b111};

        rst = 1'b1; restart = 1'b0; level = 3'b000; level_valid = 1'b0; hit = 1'b0; miss = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_idle_zero("reset");

        // Invalid levels: one level_err pulse each, no start.
        for (int i = 0; i < 2; i++) begin
            level = bad_levels[i]; level_valid = 1'b1;
            err_q.push_back(cyc + 1);
            tick();
            check("bad_level_err", level_err, 1);
            check("bad_level_state", state, 0);
            check("bad_level_speed", speed, 0);
        end
        level_valid = 1'b0; level = 3'b000;
        tick();
        check("err_clears", level_err, 0);

        // Easy game: 8 spawns every 8 cycles, first at E8.
        level = 3'b001; level_valid = 1'b1;
        tick();
        e0 = cyc;
        check("easy_state", state, 1);
        check("easy_speed", speed, 1);
        check("easy_total", note_total, 8);
        check("easy_left", notes_left, 8);
        check("easy_playing", playing, 1);
        push_spawns(e0, 8, 8, 8);
        repeat (64) tick();
        check("easy_drain", state, 2);
        check("easy_left_end", notes_left, 0);

        // Saturation: 8 hits fill resolved, a 9th in the last DRAIN cycle still scores.
        hit = 1'b1;
        repeat (8) tick();
        check("sat_still_drain", state, 2);
        check("sat_resolved", dut.resolved_q, 8);
        tick();
        check("sat_done", state, 3);
        check("sat_score9", score, 9);
        check("sat_resolved_cap", dut.resolved_q, 8);
        repeat (2) tick();
        hit = 1'b0;
        tick();
        check("done_hits_ignored", score, 9);
        check("done_game_over", game_over, 1);
        check("done_speed_hold", speed, 1);

        // Restart from DONE, then a stale held selection must not start a game.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_idle_zero("restart_done");
        repeat (4) tick();
        check("stale_001_idle", state, 0);
        level = 3'b010;
        repeat (3) tick();
        check("stale_010_idle", state, 0);
        check("stale_010_speed", speed, 0);
        level_valid = 1'b0;
        tick();
        level_valid = 1'b1;
        tick();
        e0 = cyc;
        check("mid_state", state, 1);
        check("mid_speed", speed, 2);
        check("mid_total", note_total, 12);

        // Mid game: 3 spawns, then restart on the edge where the 4th would land.
        push_spawns(e0, 3, 4, 12);
        for (int i = 0; i < 15; i++) begin
            hit = (i == 2);
            tick();
        end
        hit = 1'b0;
        check("mid_score", score, 1);
        check("mid_left", notes_left, 9);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_idle_zero("restart_play");
        repeat (10) tick();
        check("post_restart_idle", state, 0);

        // Hard game: 16 spawns every 2 cycles, 12 hits and 4 misses.
        level_valid = 1'b0;
        tick();
        level = 3'b100; level_valid = 1'b1;
        tick();
        e0 = cyc;
        check("hard_speed", speed, 4);
        check("hard_total", note_total, 16);
        push_spawns(e0, 16, 2, 16);
        for (int i = 0; i < 32; i++) begin
            hit = (i >= 5 && i <= 8);
            tick();
        end
        hit = 1'b0;
        check("hard_drain", state, 2);
        check("hard_play_score", score, 4);
        for (int i = 0; i < 11; i++) begin
            hit  = drain_vec[i][1];
            miss = drain_vec[i][0];
            tick();
        end
        hit = 1'b0; miss = 1'b0;
        check("hard_last_drain", state, 2);
        tick();
        check("hard_done", state, 3);
        check("hard_score", score, 12);
        check("hard_game_over", game_over, 1);
        check("hard_playing", playing, 0);
        check("hard_total_hold", note_total, 16);

        // Reset mid-DRAIN with restart asserted together.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        level_valid = 1'b0;
        tick();
        level_valid = 1'b1;
        tick();
        e0 = cyc;
        push_spawns(e0, 16, 2, 16);
        repeat (33) tick();
        check("rst_pre_drain", state, 2);
        rst = 1'b1; restart = 1'b1; level = 3'b001;
        tick();
        check_idle_zero("rst_drain");
        rst = 1'b0; restart = 1'b0;
        tick();
        // Reset leaves armed set, so the held valid selection starts at once.
        check("rst_armed_start", state, 1);
        check("rst_armed_speed", speed, 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("final_idle", state, 0);
        repeat (3) tick();

        check("spawn_queue_drained", spawn_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
